alu_exec_ctrl: RTL and testbench

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

---
 rtl/alu_pkg.sv | 95 +++++++++
 rtl/mul_div_iter.sv | 71 +++++++
 rtl/alu_exec_ctrl.sv | 98 +++++++++
 tb/tb_alu_exec_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes, main-decoder op encodings,
// iterative-unit FSM states and the shared combinational decoder.
package alu_pkg;

  typedef enum logic [4:0] {
    C_ADD  = 5'd0,
    C_SUB  = 5'd1,
    C_AND  = 5'd2,
    C_OR   = 5'd3,
    C_XOR  = 5'd4,
    C_NOR  = 5'd5,
    C_SLL  = 5'd6,
    C_SRL  = 5'd7,
    C_BEQ  = 5'd8,
    C_BNE  = 5'd9,
    C_BGE  = 5'd10,
    C_BGT  = 5'd11,
    C_BLE  = 5'd12,
    C_BLT  = 5'd13,
    C_P14  = 5'd14,
    C_P15  = 5'd15,
    C_MUL  = 5'd16,
    C_DIVU = 5'd17,
    C_NOP  = 5'd31
  } alu_code_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_OR    = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_BNE   = 4'b0110;
  localparam logic [3:0] OP_BGE   = 4'b0111;
  localparam logic [3:0] OP_BGT   = 4'b1000;
  localparam logic [3:0] OP_BLE   = 4'b1001;
  localparam logic [3:0] OP_BLT   = 4'b1010;

  localparam logic [5:0] FN_MUL  = 6'h18;
  localparam logic [5:0] FN_DIVU = 6'h1A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_DONE
  } state_t;

  typedef struct packed {
    alu_code_t code;
    logic      illegal;
  } dec_t;

  // Wide inputs so any ALUOP_W/FUNCT_W fits; nonzero upper bits are illegal.
  function automatic dec_t alu_decode(
    input logic [31:0] op,
    input logic [31:0] fn
  );
    dec_t d;
    logic op_ok;
    logic fn_ok;
    d = '{C_NOP, 1'b1};
    op_ok = (op[31:4] == '0);
    fn_ok = (fn[31:6] == '0);
    if (op_ok) begin
      unique case (op[3:0])
        OP_ADD: d = '{C_ADD, 1'b0};
        OP_SUB: d = '{C_SUB, 1'b0};
        OP_AND: d = '{C_AND, 1'b0};
        OP_OR:  d = '{C_OR,  1'b0};
        OP_BEQ: d = '{C_BEQ, 1'b0};
        OP_BNE: d = '{C_BNE, 1'b0};
        OP_BGE: d = '{C_BGE, 1'b0};
        OP_BGT: d = '{C_BGT, 1'b0};
        OP_BLE: d = '{C_BLE, 1'b0};
        OP_BLT: d = '{C_BLT, 1'b0};
        OP_RTYPE: begin
          if (fn_ok) begin
            unique case (fn[5:0])
              6'h00, 6'h01, 6'h02, 6'h03,
              6'h04, 6'h05, 6'h06, 6'h07,
              6'h0E, 6'h0F:
                d = '{alu_code_t'(fn[4:0]), 1'b0};
              FN_MUL:  d = '{C_MUL,  1'b0};
              FN_DIVU: d = '{C_DIVU, 1'b0};
              default: d = '{C_NOP,  1'b1};
            endcase
          end
        end
        default: d = '{C_NOP, 1'b1};
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: one-bit-per-cycle unsigned shift-add multiplier
// and restoring divider sharing a single double-width register.
module mul_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [2*DATA_W-1:0] p;
  logic [2*DATA_W-1:0] p_n;
  logic [DATA_W-1:0]   b_q;
  logic [CW-1:0]       cnt;
  logic                run;
  logic                div_q;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     r_sh;
  logic [DATA_W:0]     diff;
  logic                ge;

  // Mul: p = {acc, multiplier}. Div: p = {remainder, quotient}.
  always_comb begin
    sum  = {1'b0, p[2*DATA_W-1:DATA_W]}
         + (p[0] ? {1'b0, b_q} : '0);
    r_sh = {p[2*DATA_W-1:DATA_W], p[DATA_W-1]};
    diff = r_sh - {1'b0, b_q};
    ge   = !diff[DATA_W];
    if (div_q) begin
      p_n = {(ge ? diff[DATA_W-1:0] : r_sh[DATA_W-1:0]),
             p[DATA_W-2:0], ge};
    end else begin
      p_n = {sum, p[DATA_W-1:1]};
    end
  end

  // Result is taken from p_n during the last iteration cycle.
  assign done = run && (cnt == LAST);
  assign lo   = p_n[DATA_W-1:0];
  assign hi   = p_n[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      b_q   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      div_q <= 1'b0;
    end else if (start) begin
      p     <= {{DATA_W{1'b0}}, a};
      b_q   <= b;
      div_q <= is_div;
      cnt   <= '0;
      run   <= 1'b1;
    end else if (run) begin
      p   <= p_n;
      cnt <= cnt + CW'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: ALU control decode with a valid/ready response
// stage and an iterative MUL/DIVU unit that stalls the pipeline.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 5,
  parameter int ALUOP_W = 4,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [DATA_W-1:0]  src_a,
  input  logic [DATA_W-1:0]  src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               illegal,
  output logic [DATA_W-1:0]  lo,
  output logic [DATA_W-1:0]  hi,
  output logic               busy
);

  localparam logic [CTRL_W-1:0] NOP_W = CTRL_W'(C_NOP);

  state_t            state;
  state_t            state_n;
  dec_t              dec;
  logic              acc;
  logic              is_iter;
  logic              done;
  logic [DATA_W-1:0] it_lo;
  logic [DATA_W-1:0] it_hi;

  assign dec      = alu_decode(32'(aluop), 32'(funct));
  assign is_iter  = (dec.code == C_MUL) || (dec.code == C_DIVU);
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  mul_div_iter #(
    .DATA_W(DATA_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (acc && is_iter),
    .is_div (dec.code == C_DIVU),
    .a      (src_a),
    .b      (src_b),
    .done   (done),
    .lo     (it_lo),
    .hi     (it_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (acc && is_iter) state_n = S_ITER;
      S_ITER:  if (done)           state_n = S_DONE;
      S_DONE:  if (out_ready)      state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Acceptance only happens when no response is held, so loading here
  // never disturbs a stalled response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      alu_ctrl  <= NOP_W;
      lo        <= '0;
      hi        <= '0;
    end else if (acc) begin
      out_valid <= !is_iter;
      alu_ctrl  <= CTRL_W'(dec.code);
      illegal   <= dec.illegal;
      lo        <= '0;
      hi        <= '0;
    end else if (state == S_ITER && done) begin
      out_valid <= 1'b1;
      lo        <= it_lo;
      hi        <= it_hi;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed bench with a response scoreboard
// for the ALU control decode and iterative MUL/DIVU unit.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_ctrl;
  logic        illegal;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [4:0]  ctrl;
    logic        ill;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  exp_t q[$];

  alu_exec_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluop     (aluop),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [3:0]  op,
    input logic [5:0]  fn,
    input logic [31:0] a,
    input logic [31:0] b
  );
    exp_t e;
    logic [63:0] p;
    e.ctrl = 5'd31;
    e.lo = '0;
    e.hi = '0;
    e.lat = 1;
    case (op)
      4'd0:  e.ctrl = 5'd0;
      4'd1:  e.ctrl = 5'd1;
      4'd3:  e.ctrl = 5'd2;
      4'd4:  e.ctrl = 5'd3;
      4'd5:  e.ctrl = 5'd8;
      4'd6:  e.ctrl = 5'd9;
      4'd7:  e.ctrl = 5'd10;
      4'd8:  e.ctrl = 5'd11;
      4'd9:  e.ctrl = 5'd12;
      4'd10: e.ctrl = 5'd13;
      4'd2: begin
        if (fn <= 6'h07 || fn == 6'h0E || fn == 6'h0F) begin
          e.ctrl = fn[4:0];
        end else if (fn == 6'h18) begin
          e.ctrl = 5'd16;
          e.lat = 33;
          p = {32'd0, a} * {32'd0, b};
          e.lo = p[31:0];
          e.hi = p[63:32];
        end else if (fn == 6'h1A) begin
          e.ctrl = 5'd17;
          e.lat = 33;
          if (b == 0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
          end else begin
            e.lo = a / b;
            e.hi = a % b;
          end
        end
      end
      default: e.ctrl = 5'd31;
    endcase
    e.ill = (e.ctrl == 5'd31);
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [3:0]  op,
    input logic [5:0]  fn,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("send_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    aluop = op;
    funct = fn;
    src_a = a;
    src_b = b;
    q.push_back(model(op, fn, a, b));
    step();
    acc_cyc = cyc;
    in_valid = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic compare_now(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, "_ctrl"}, 64'(alu_ctrl), 64'(e.ctrl));
      chk({tag, "_ill"}, 64'(illegal), 64'(e.ill));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lat"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
    end
  endtask

  task automatic recv(input string tag);
    wait_valid(tag);
    compare_now(tag);
    step();
  endtask

  initial begin
    logic [5:0]  fl[12];
    logic [4:0]  hold_ctrl;
    int          seen;

    fl = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
           6'h06, 6'h07, 6'h0E, 6'h0F, 6'h3F, 6'h08};
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    aluop = '0;
    funct = '0;
    src_a = '0;
    src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctrl", 64'(alu_ctrl), 64'd31);
    chk("rst_ill", 64'(illegal), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rdy_after_rst", 64'(in_ready), 64'd1);

    send(4'b0010, 6'h04, 32'd0, 32'd0);
    recv("rt_xor");

    for (int i = 0; i < 16; i++) begin
      send(i[3:0], 6'h20, $urandom, $urandom);
      recv($sformatf("aluop%0d", i));
    end

    foreach (fl[k]) begin
      send(4'b0010, fl[k], $urandom, $urandom);
      recv($sformatf("funct%0h", fl[k]));
    end

    // Two single-cycle ops at full rate.
    in_valid = 1'b1;
    aluop = 4'b0000;
    funct = 6'h00;
    step();
    chk("b2b0_valid", 64'(out_valid), 64'd1);
    chk("b2b0_ctrl", 64'(alu_ctrl), 64'd0);
    chk("b2b0_rdy", 64'(in_ready), 64'd1);
    aluop = 4'b0001;
    step();
    chk("b2b1_valid", 64'(out_valid), 64'd1);
    chk("b2b1_ctrl", 64'(alu_ctrl), 64'd1);
    in_valid = 1'b0;
    step();
    chk("b2b_idle", 64'(out_valid), 64'd0);

    send(4'b0010, 6'h18, 32'hFFFF_FFFF, 32'd2);
    chk("mul_busy", 64'(busy), 64'd1);
    chk("mul_rdy", 64'(in_ready), 64'd0);
    wait_valid("mul_max");
    chk("mul_lo_k", 64'(lo), 64'hFFFF_FFFE);
    chk("mul_hi_k", 64'(hi), 64'h1);
    compare_now("mul_max");
    step();
    chk("mul_busy_end", 64'(busy), 64'd0);

    send(4'b0010, 6'h1A, 32'd100, 32'd7);
    recv("div_100_7");
    send(4'b0010, 6'h1A, 32'd5, 32'd0);
    recv("div_by0");
    for (int i = 0; i < 3; i++) begin
      send(4'b0010, 6'h18, $urandom, $urandom);
      recv($sformatf("mul_r%0d", i));
      send(4'b0010, 6'h1A, $urandom, $urandom_range(1, 5000));
      recv($sformatf("div_r%0d", i));
    end

    // Response held under back-pressure, then next request accepted.
    out_ready = 1'b0;
    send(4'b0011, 6'h00, 32'd0, 32'd0);
    wait_valid("stall");
    compare_now("stall");
    hold_ctrl = alu_ctrl;
    in_valid = 1'b1;
    aluop = 4'b0100;
    funct = 6'h00;
    q.push_back(model(4'b0100, 6'h00, 32'd0, 32'd0));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ctrl", 64'(alu_ctrl), 64'(hold_ctrl));
      chk("stall_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    acc_cyc = cyc;
    in_valid = 1'b0;
    recv("stall_next");

    // Reset during MUL iterations.
    send(4'b0010, 6'h18, 32'h1234, 32'h5678);
    repeat (9) step();
    chk("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ctrl", 64'(alu_ctrl), 64'd31);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("arst_rdy", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    chk("arst_no_resp", 64'(seen), 64'd0);
    send(4'b0010, 6'h0F, 32'd0, 32'd0);
    recv("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
